// File: rtl/nz_scatter_5.sv
// Scatters beats of non-zero bit addresses back into a SPAD_WIDTH-bit occupancy mask,
// with popcount and per-vector sticky duplicate / out-of-range flags.
//
// state | meaning
// ACCUM | accepting beats, OR-ing decoded addresses into the accumulator
// HOLD  | finished vector presented on the outputs until the consumer takes it
module nz_scatter_5 #(
  parameter int DIM        = 5,
  parameter int SPAD_WIDTH = 64,
  parameter int ADDR_WIDTH = $clog2(SPAD_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH*DIM-1:0] addr_bus,
  input  logic [2:0]                addr_cnt,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SPAD_WIDTH-1:0]     mask_out,
  output logic [ADDR_WIDTH:0]       nnz_out,
  output logic                      dup_err,
  output logic                      range_err
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [SPAD_WIDTH-1:0]   acc_q;
  logic                    dup_acc_q;
  logic                    rng_acc_q;
  logic [SPAD_WIDTH-1:0]   mask_q;
  logic [ADDR_WIDTH:0]     nnz_q;
  logic                    dup_q;
  logic                    rng_q;

  logic [2:0]              cnt_eff;
  logic [ADDR_WIDTH-1:0]   slot_addr [DIM];
  logic [DIM-1:0]          slot_vld;
  logic [DIM-1:0]          slot_inr;
  logic [SPAD_WIDTH-1:0]   new_mask;
  logic [SPAD_WIDTH-1:0]   merged;
  logic [ADDR_WIDTH:0]     merged_pop;
  logic                    beat_dup;
  logic                    beat_rng;
  logic                    accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    cnt_eff  = (addr_cnt > 3'(DIM)) ? 3'(DIM) : addr_cnt;
    new_mask = '0;
    beat_dup = 1'b0;
    beat_rng = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      slot_addr[i] = addr_bus[(DIM-i)*ADDR_WIDTH-1 -: ADDR_WIDTH];
      slot_vld[i]  = cnt_eff > 3'(i);
      slot_inr[i]  = {1'b0, slot_addr[i]} < (ADDR_WIDTH+1)'(SPAD_WIDTH);
    end
    for (int i = 0; i < DIM; i++) begin
      if (slot_vld[i]) begin
        if (slot_inr[i]) begin
          if (acc_q[slot_addr[i]]) beat_dup = 1'b1;
          new_mask[slot_addr[i]] = 1'b1;
        end else begin
          beat_rng = 1'b1;
        end
        // repeats inside one beat never show up in acc_q, so compare slots pairwise
        for (int j = 0; j < i; j++) begin
          if (slot_vld[j] && (slot_addr[j] == slot_addr[i])) beat_dup = 1'b1;
        end
      end
    end
    merged     = acc_q | new_mask;
    merged_pop = '0;
    for (int b = 0; b < SPAD_WIDTH; b++) begin
      merged_pop = merged_pop + (ADDR_WIDTH+1)'(merged[b]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      dup_acc_q   <= 1'b0;
      rng_acc_q   <= 1'b0;
      mask_q      <= '0;
      nnz_q       <= '0;
      dup_q       <= 1'b0;
      rng_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (in_last) begin
              mask_q      <= merged;
              nnz_q       <= merged_pop;
              dup_q       <= dup_acc_q | beat_dup;
              rng_q       <= rng_acc_q | beat_rng;
              acc_q       <= '0;
              dup_acc_q   <= 1'b0;
              rng_acc_q   <= 1'b0;
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              acc_q     <= merged;
              dup_acc_q <= dup_acc_q | beat_dup;
              rng_acc_q <= rng_acc_q | beat_rng;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mask_out  = mask_q;
  assign nnz_out   = nnz_q;
  assign dup_err   = dup_q;
  assign range_err = rng_q;

endmodule

// File: tb/tb_nz_scatter_5.sv
// Scoreboard bench for nz_scatter_5: a bit-set model pushes expected vectors when
// the last beat is accepted; a monitor pops and compares on each output handshake.
module tb_nz_scatter_5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] addr_bus;
  logic [2:0]  addr_cnt;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] mask_out;
  logic [6:0]  nnz_out;
  logic        dup_err;
  logic        range_err;

  nz_scatter_5 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr_bus  (addr_bus),
    .addr_cnt  (addr_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mask_out  (mask_out),
    .nnz_out   (nnz_out),
    .dup_err   (dup_err),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] m;
    logic [6:0]  n;
    logic        d;
    logic        r;
  } exp_t;

  exp_t        sb_q [$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] m_acc = '0;
  logic        m_dup = 1'b0;
  logic        m_rng = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pk(input logic [5:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic model_beat(input logic [29:0] bus, input logic [2:0] cnt, input logic last);
    int ce;
    logic [5:0] a;
    exp_t e;
    ce = (cnt > 3'd5) ? 5 : int'(cnt);
    for (int i = 0; i < ce; i++) begin
      a = bus[(5-i)*6-1 -: 6];
      if (m_acc[a]) m_dup = 1'b1;
      m_acc[a] = 1'b1;
    end
    if (last) begin
      e.m = m_acc;
      e.n = 7'($countones(m_acc));
      e.d = m_dup;
      e.r = m_rng;
      sb_q.push_back(e);
      m_acc = '0;
      m_dup = 1'b0;
      m_rng = 1'b0;
    end
  endtask

  task automatic send_beat(input logic [29:0] bus, input logic [2:0] cnt, input logic last,
                           output int waits);
    logic took;
    in_valid = 1'b1;
    addr_bus = bus;
    addr_cnt = cnt;
    in_last  = last;
    waits    = 0;
    took     = 1'b0;
    while (!took && waits < 50) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    in_valid = 1'b0;
    if (!took) chk("accept_timeout", 64'd0, 64'd1);
    else model_beat(bus, cnt, last);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ready_after_take", 64'(in_ready), 64'd1);
    chk("valid_after_take", 64'(out_valid), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_mask", mask_out, e.m);
        chk("sb_nnz", 64'(nnz_out), 64'(e.n));
        chk("sb_dup", 64'(dup_err), 64'(e.d));
        chk("sb_rng", 64'(range_err), 64'(e.r));
      end
    end
  end

  initial begin
    int w;
    logic [29:0] bus;
    logic [63:0] held;
    int v;

    reset     = 1'b1;
    in_valid  = 1'b0;
    addr_bus  = '0;
    addr_cnt  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mask", mask_out, 64'd0);
    chk("rst_nnz", 64'(nnz_out), 64'd0);
    chk("rst_errs", 64'({dup_err, range_err}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // single beat
    send_beat(pk(6'd3, 6'd10, 6'd63, 6'd0, 6'd0), 3'd3, 1'b1, w);
    chk("single_latency", 64'(out_valid), 64'd1);
    chk("single_mask", mask_out, 64'h8000_0000_0000_0408);
    chk("single_nnz", 64'(nnz_out), 64'd3);
    drain();

    // multi beat, in_ready held low until the consumer takes it
    send_beat(pk(6'd0, 6'd1, 6'd2, 6'd3, 6'd4), 3'd5, 1'b0, w);
    send_beat(pk(6'd5, 6'd6, 6'd0, 6'd0, 6'd0), 3'd2, 1'b1, w);
    chk("multi_mask", mask_out, 64'h7F);
    chk("multi_nnz", 64'(nnz_out), 64'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("multi_hold_ready", 64'(in_ready), 64'd0);
    drain();

    // duplicates across beats, then a clean vector
    send_beat(pk(6'd7, 6'd0, 6'd0, 6'd0, 6'd0), 3'd1, 1'b0, w);
    send_beat(pk(6'd7, 6'd8, 6'd0, 6'd0, 6'd0), 3'd2, 1'b1, w);
    chk("dup_mask", mask_out, 64'h180);
    chk("dup_nnz", 64'(nnz_out), 64'd2);
    chk("dup_flag", 64'(dup_err), 64'd1);
    drain();
    send_beat(pk(6'd1, 6'd2, 6'd0, 6'd0, 6'd0), 3'd2, 1'b1, w);
    chk("clean_dup", 64'(dup_err), 64'd0);
    drain();

    // count clamp and duplicate inside a single beat
    send_beat(pk(6'd12, 6'd13, 6'd14, 6'd15, 6'd16), 3'd7, 1'b1, w);
    chk("clamp_nnz", 64'(nnz_out), 64'd5);
    drain();
    send_beat(pk(6'd12, 6'd12, 6'd0, 6'd0, 6'd0), 3'd2, 1'b1, w);
    chk("inbeat_dup", 64'(dup_err), 64'd1);
    drain();

    // full mask over 13 beats
    for (int b = 0; b < 13; b++) begin
      bus = '0;
      for (int k = 0; k < 5; k++) begin
        v = b * 5 + k;
        bus[(5-k)*6-1 -: 6] = (v < 64) ? 6'(v) : 6'd0;
      end
      send_beat(bus, (b == 12) ? 3'd4 : 3'd5, b == 12, w);
    end
    chk("full_mask", mask_out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("full_nnz", 64'(nnz_out), 64'd64);
    chk("full_dup", 64'(dup_err), 64'd0);
    drain();

    // empty last beat
    send_beat(pk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0), 3'd0, 1'b1, w);
    chk("empty_mask", mask_out, 64'd0);
    chk("empty_nnz", 64'(nnz_out), 64'd0);
    drain();
    send_beat(pk(6'd30, 6'd0, 6'd0, 6'd0, 6'd0), 3'd1, 1'b0, w);
    send_beat(pk(6'd31, 6'd0, 6'd0, 6'd0, 6'd0), 3'd0, 1'b1, w);
    chk("cnt0_last_mask", mask_out, 64'h4000_0000);
    drain();

    // backpressure with a pending beat
    send_beat(pk(6'd40, 6'd0, 6'd0, 6'd0, 6'd0), 3'd1, 1'b1, w);
    held     = mask_out;
    in_valid = 1'b1;
    addr_bus = pk(6'd41, 6'd42, 6'd0, 6'd0, 6'd0);
    addr_cnt = 3'd2;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stable", mask_out, held);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_held_mask", mask_out, held);
    send_beat(pk(6'd41, 6'd42, 6'd0, 6'd0, 6'd0), 3'd2, 1'b1, w);
    chk("bp_accept_delay", 64'(w), 64'd1);
    chk("bp_mask", mask_out, (64'd1 << 41) | (64'd1 << 42));
    drain();

    // reset mid-vector
    send_beat(pk(6'd9, 6'd0, 6'd0, 6'd0, 6'd0), 3'd1, 1'b0, w);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_mask", mask_out, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    m_acc = '0;
    m_dup = 1'b0;
    m_rng = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_beat(pk(6'd20, 6'd0, 6'd0, 6'd0, 6'd0), 3'd1, 1'b1, w);
    chk("postrst_mask", mask_out, 64'd1 << 20);
    chk("postrst_nnz", 64'(nnz_out), 64'd1);
    drain();

    repeat (2) @(posedge clk);
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
